// File: rtl/ucie_pkg.sv
// rtl/ucie_pkg.sv - shared constants and state type for the sideband message assembler
package ucie_pkg;

  localparam int SB_MSG_BYTES = 8;
  localparam int SB_MSG_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } sb_asm_state_t;

endpackage

// File: rtl/ucie_sat_counter.sv
// rtl/ucie_sat_counter.sv - saturating event counter, sticks at all-ones
module ucie_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/ucie_sb_msg_assembler.sv
// rtl/ucie_sb_msg_assembler.sv - packs sideband bytes into checksummed 64-bit messages
module ucie_sb_msg_assembler
  import ucie_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk_sb,
  input  logic                    rst,
  input  logic [7:0]              sb_data_in,
  input  logic                    sb_valid_in,
  output logic                    sb_ready_out,
  output logic [SB_MSG_WIDTH-1:0] msg_data,
  output logic                    msg_valid,
  input  logic                    msg_ready,
  output logic                    err_checksum,
  output logic                    err_timeout,
  output logic [15:0]             msg_count,
  output logic [15:0]             err_count
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        LAST_BYTE = 3'(SB_MSG_BYTES - 1);

  sb_asm_state_t           r_state;
  sb_asm_state_t           w_state_next;
  logic [2:0]              r_byte_cnt;
  logic [IDLE_W-1:0]       r_idle_cnt;
  logic [SB_MSG_WIDTH-9:0] r_asm;
  logic [SB_MSG_WIDTH-1:0] r_hold;
  logic [7:0]              r_csum;

  logic                    w_accept;
  logic                    w_csum_ok;
  logic                    w_out_free;
  logic                    w_deliver;
  logic                    w_to_hold;
  logic                    w_hold_pop;
  logic                    w_bad;
  logic                    w_timeout;
  logic                    w_load_out;
  logic [SB_MSG_WIDTH-1:0] w_full_msg;

  assign w_accept   = sb_valid_in & sb_ready_out;
  assign w_full_msg = {sb_data_in, r_asm};
  assign w_csum_ok  = (sb_data_in == r_csum);
  assign w_out_free = ~msg_valid | msg_ready;
  assign w_load_out = w_deliver | w_hold_pop;

  always_ff @(posedge clk_sb or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_deliver    = 1'b0;
    w_to_hold    = 1'b0;
    w_hold_pop   = 1'b0;
    w_bad        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = COLLECT;
      end
      COLLECT: begin
        if (w_accept) begin
          if (r_byte_cnt == LAST_BYTE) begin
            if (!w_csum_ok) begin
              w_bad        = 1'b1;
              w_state_next = IDLE;
            end else if (w_out_free) begin
              w_deliver    = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_to_hold    = 1'b1;
              w_state_next = HOLD;
            end
          end
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      HOLD: begin
        if (msg_ready) begin
          w_hold_pop   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Bytes shift in from the top so byte 0 lands in [7:0] once byte 6 arrives;
  // r_csum carries the running XOR of bytes 0..6 for comparison with byte 7.
  always_ff @(posedge clk_sb or posedge rst) begin
    if (rst) begin
      sb_ready_out <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      r_byte_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_asm        <= '0;
      r_hold       <= '0;
      r_csum       <= '0;
      msg_data     <= '0;
      msg_valid    <= 1'b0;
    end else begin
      sb_ready_out <= (w_state_next != HOLD);
      err_checksum <= w_bad;
      err_timeout  <= w_timeout;

      if (w_state_next != COLLECT) begin
        r_byte_cnt <= '0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 3'd1;
      end

      if ((r_state == COLLECT) && (w_state_next == COLLECT) && !w_accept) begin
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end else begin
        r_idle_cnt <= '0;
      end

      if (w_accept) begin
        r_asm  <= {sb_data_in, r_asm[SB_MSG_WIDTH-9:8]};
        r_csum <= (r_state == IDLE) ? sb_data_in : (r_csum ^ sb_data_in);
      end

      if (w_to_hold) r_hold <= w_full_msg;

      if (w_load_out) begin
        msg_data  <= w_deliver ? w_full_msg : r_hold;
        msg_valid <= 1'b1;
      end else if (msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

  ucie_sat_counter #(.WIDTH(16)) u_msg_cnt (
    .clk   (clk_sb),
    .rst   (rst),
    .inc   (w_load_out),
    .count (msg_count)
  );

  ucie_sat_counter #(.WIDTH(16)) u_err_cnt (
    .clk   (clk_sb),
    .rst   (rst),
    .inc   (w_bad | w_timeout),
    .count (err_count)
  );

endmodule

// File: tb/tb_ucie_sb_msg_assembler.sv
// tb/tb_ucie_sb_msg_assembler.sv - scoreboard bench for the sideband message assembler
module tb_ucie_sb_msg_assembler;

  logic        clk_sb = 1'b0;
  logic        rst;
  logic [7:0]  sb_data_in;
  logic        sb_valid_in;
  logic        sb_ready_out;
  logic [63:0] msg_data;
  logic        msg_valid;
  logic        msg_ready;
  logic        err_checksum;
  logic        err_timeout;
  logic [15:0] msg_count;
  logic [15:0] err_count;

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_ck_seen = 0;
  int          n_to_seen = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [63:0] prev_data = '0;
  logic        prev_stall = 1'b0;

  ucie_sb_msg_assembler #(.TIMEOUT_CYCLES(64)) dut (
    .clk_sb       (clk_sb),
    .rst          (rst),
    .sb_data_in   (sb_data_in),
    .sb_valid_in  (sb_valid_in),
    .sb_ready_out (sb_ready_out),
    .msg_data     (msg_data),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .msg_count    (msg_count),
    .err_count    (err_count)
  );

  always #5 clk_sb = ~clk_sb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake, tallies error pulses
  always @(negedge clk_sb) begin
    if (!rst) begin
      if (err_checksum) n_ck_seen++;
      if (err_timeout) n_to_seen++;
      if (msg_valid && !msg_ready && prev_stall) check("hold_stable", msg_data, prev_data);
      if (msg_valid && msg_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_msg: got %h expected none", msg_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("msg_data", msg_data, mon_exp);
        end
      end
      prev_stall = msg_valid && !msg_ready;
      prev_data  = msg_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk_sb);
    sb_data_in  = b;
    sb_valid_in = 1'b1;
    while (!sb_ready_out && t < 100) begin
      @(negedge clk_sb);
      t++;
    end
    if (!sb_ready_out) begin
      n_vec++;
      n_bad++;
      $display("FAIL byte_stall: got ready=0 expected ready=1 within 100 cycles");
    end
    @(posedge clk_sb);
    #1;
    sb_valid_in = 1'b0;
  endtask

  task automatic send_msg(input logic [63:0] w, input bit good);
    if (good) exp_q.push_back(w);
    for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    sb_valid_in = 1'b0;
    sb_data_in  = 8'h00;
    msg_ready   = 1'b1;
    repeat (3) @(posedge clk_sb);
    #1;
    check("rst_ready",    64'(sb_ready_out), 64'd0);
    check("rst_valid",    64'(msg_valid),    64'd0);
    check("rst_data",     msg_data,          64'd0);
    check("rst_msg_cnt",  64'(msg_count),    64'd0);
    check("rst_err_cnt",  64'(err_count),    64'd0);
    check("rst_err_ck",   64'(err_checksum), 64'd0);
    check("rst_err_to",   64'(err_timeout),  64'd0);
    @(negedge clk_sb);
    rst = 1'b0;
    @(posedge clk_sb);
    #1;
    check("ready_after_rst", 64'(sb_ready_out), 64'd1);

    send_msg(64'h0007060504030201, 1'b1);
    check("m1_valid", 64'(msg_valid), 64'd1);
    check("m1_data",  msg_data,       64'h0007060504030201);
    check("m1_count", 64'(msg_count), 64'd1);

    send_msg(64'h5507060504030201, 1'b0);
    check("ck_pulse",  64'(err_checksum), 64'd1);
    check("ck_valid",  64'(msg_valid),    64'd0);
    check("ck_errcnt", 64'(err_count),    64'd1);
    check("ck_msgcnt", 64'(msg_count),    64'd1);
    @(posedge clk_sb);
    #1;
    check("ck_pulse_end", 64'(err_checksum), 64'd0);

    send_msg(64'h7056341200FF5AA5, 1'b1);
    check("m2_count", 64'(msg_count), 64'd2);

    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (63) @(posedge clk_sb);
    #1;
    check("to_early", 64'(err_timeout), 64'd0);
    check("to_early_errcnt", 64'(err_count), 64'd1);
    @(posedge clk_sb);
    #1;
    check("to_pulse",  64'(err_timeout),  64'd1);
    check("to_errcnt", 64'(err_count),    64'd2);
    check("to_ready",  64'(sb_ready_out), 64'd1);
    send_msg(64'h7F40201008040201, 1'b1);
    check("to_next_count", 64'(msg_count), 64'd3);

    repeat (2) @(posedge clk_sb);
    #1;
    msg_ready = 1'b0;
    send_msg(64'h0007060504030201, 1'b1);
    check("bp_a_valid", 64'(msg_valid),    64'd1);
    check("bp_a_data",  msg_data,          64'h0007060504030201);
    send_msg(64'h7056341200FF5AA5, 1'b1);
    check("bp_hold_ready", 64'(sb_ready_out), 64'd0);
    check("bp_hold_data",  msg_data,          64'h0007060504030201);
    check("bp_hold_count", 64'(msg_count),    64'd4);
    repeat (3) @(posedge clk_sb);
    #1;
    check("bp_wait_ready", 64'(sb_ready_out), 64'd0);
    check("bp_wait_valid", 64'(msg_valid),    64'd1);
    msg_ready = 1'b1;
    @(posedge clk_sb);
    #1;
    msg_ready = 1'b0;
    check("bp_pop_valid", 64'(msg_valid),    64'd1);
    check("bp_pop_data",  msg_data,          64'h7056341200FF5AA5);
    check("bp_pop_ready", 64'(sb_ready_out), 64'd1);
    check("bp_pop_count", 64'(msg_count),    64'd5);
    repeat (2) @(posedge clk_sb);
    #1;
    msg_ready = 1'b1;
    @(posedge clk_sb);
    #1;
    check("bp_drained", 64'(msg_valid), 64'd0);

    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    @(negedge clk_sb);
    rst = 1'b1;
    #1;
    check("mid_rst_ready",  64'(sb_ready_out), 64'd0);
    check("mid_rst_msgcnt", 64'(msg_count),    64'd0);
    check("mid_rst_errcnt", 64'(err_count),    64'd0);
    check("mid_rst_data",   msg_data,          64'd0);
    @(negedge clk_sb);
    rst = 1'b0;
    @(posedge clk_sb);
    #1;
    check("post_rst_ready", 64'(sb_ready_out), 64'd1);
    send_msg(64'h7F40201008040201, 1'b1);
    check("post_rst_data",   msg_data,          64'h7F40201008040201);
    check("post_rst_msgcnt", 64'(msg_count),    64'd1);
    check("post_rst_errcnt", 64'(err_count),    64'd0);

    @(negedge clk_sb);
    force dut.u_err_cnt.r_count = 16'hFFFE;
    #1;
    release dut.u_err_cnt.r_count;
    check("sat_preset", 64'(err_count), 64'hFFFE);
    send_msg(64'h5507060504030201, 1'b0);
    check("sat_first", 64'(err_count), 64'hFFFF);
    send_msg(64'h00A5A5A5A5A5A5A5, 1'b0);
    @(posedge clk_sb);
    #1;
    check("sat_held",   64'(err_count), 64'hFFFF);
    check("sat_msgcnt", 64'(msg_count), 64'd1);

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk_sb);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("ck_pulses",     64'(n_ck_seen),    64'd3);
    check("to_pulses",     64'(n_to_seen),    64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
